// File: rtl/fat32_file_tracker.sv
// rtl/fat32_file_tracker.sv - FAT32 file-position tracker with START/BUSY/DONE handshake
module fat32_file_tracker #(
  parameter int unsigned AW           = 32,
  parameter int unsigned BLK_LOG2     = 9,
  parameter int unsigned FAT_ENT_LOG2 = 7,
  parameter int unsigned FIRST_CLUST  = 4,
  parameter int unsigned FAT_UPD_OFS  = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    CLR,
  input  logic [AW-1:0]           ADD_BLOCKS,
  input  logic [2:0]              CLUST_SHIFT,
  input  logic [AW-1:0]           FILE_BEGIN_ADDR,
  input  logic [AW-1:0]           FAT1_BEGIN_ADDR,
  input  logic [AW-1:0]           FAT2_BEGIN_ADDR,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR,
  output logic [AW-1:0]           BLOCKS_TOTAL,
  output logic [AW-1:0]           FILE_SIZE_BYTES,
  output logic [AW-1:0]           ADDR_RESUME,
  output logic [AW-1:0]           CLUST_NUM_EOF,
  output logic [AW-1:0]           FIRST_CLUST_UPD_FAT,
  output logic [AW-1:0]           ADDR_UPD_FAT1,
  output logic [AW-1:0]           ADDR_UPD_FAT2,
  output logic [FAT_ENT_LOG2+1:0] FAT_ENTRY_BYTE_OFS
);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DIV, S_FAT, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           add_q, add_d;
  logic [2:0]              shift_q, shift_d;
  logic [AW-1:0]           file_q, file_d;
  logic [AW-1:0]           fat1_q, fat1_d;
  logic [AW-1:0]           fat2_q, fat2_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [AW-1:0]           clust_q, clust_d;
  logic [AW-1:0]           page_q, page_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic [AW-1:0]           blocks_q, blocks_d;
  logic [AW-1:0]           size_q, size_d;
  logic [AW-1:0]           resume_q, resume_d;
  logic [AW-1:0]           eof_q, eof_d;
  logic [AW-1:0]           first_upd_q, first_upd_d;
  logic [AW-1:0]           upd_fat1_q, upd_fat1_d;
  logic [AW-1:0]           upd_fat2_q, upd_fat2_d;
  logic [FAT_ENT_LOG2+1:0] ofs_q, ofs_d;

  logic [AW:0]             sum;
  logic [AW-1:0]           eof_c;
  logic                    size_lost;

  // Next-state and datapath: one pipeline step per state, outputs published in S_OUT.
  always_comb begin
    state_d     = state_q;
    add_d       = add_q;
    shift_d     = shift_q;
    file_d      = file_q;
    fat1_d      = fat1_q;
    fat2_d      = fat2_q;
    acc_d       = acc_q;
    clust_d     = clust_q;
    page_d      = page_q;
    err_d       = err_q;
    done_d      = 1'b0;
    blocks_d    = blocks_q;
    size_d      = size_q;
    resume_d    = resume_q;
    eof_d       = eof_q;
    first_upd_d = first_upd_q;
    upd_fat1_d  = upd_fat1_q;
    upd_fat2_d  = upd_fat2_q;
    ofs_d       = ofs_q;

    sum       = {1'b0, acc_q} + {1'b0, add_q};
    eof_c     = clust_q + AW'(FIRST_CLUST);
    // Any set bit in the top BLK_LOG2 positions would fall off the byte-size shift.
    size_lost = (acc_q >> (AW - BLK_LOG2)) != '0;

    case (state_q)
      S_IDLE: begin
        // CLR takes effect before a simultaneous START so the add starts from zero.
        if (CLR) begin
          acc_d = '0;
          err_d = 1'b0;
        end
        if (START) begin
          add_d   = ADD_BLOCKS;
          shift_d = CLUST_SHIFT;
          file_d  = FILE_BEGIN_ADDR;
          fat1_d  = FAT1_BEGIN_ADDR;
          fat2_d  = FAT2_BEGIN_ADDR;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (sum[AW]) begin
          acc_d = '1;
          err_d = 1'b1;
        end else begin
          acc_d = sum[AW-1:0];
        end
        state_d = S_DIV;
      end
      S_DIV: begin
        clust_d = acc_q >> shift_q;
        state_d = S_FAT;
      end
      S_FAT: begin
        page_d  = clust_q >> FAT_ENT_LOG2;
        state_d = S_OUT;
      end
      S_OUT: begin
        blocks_d = acc_q;
        if (size_lost) begin
          size_d = '1;
          err_d  = 1'b1;
        end else begin
          size_d = acc_q << BLK_LOG2;
        end
        resume_d    = file_q + acc_q;
        eof_d       = eof_c;
        first_upd_d = (page_q << FAT_ENT_LOG2) + AW'(FAT_UPD_OFS);
        upd_fat1_d  = fat1_q + page_q;
        upd_fat2_d  = fat2_q + page_q;
        ofs_d       = {eof_c[FAT_ENT_LOG2-1:0], 2'b00};
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      add_q       <= '0;
      shift_q     <= '0;
      file_q      <= '0;
      fat1_q      <= '0;
      fat2_q      <= '0;
      acc_q       <= '0;
      clust_q     <= '0;
      page_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      blocks_q    <= '0;
      size_q      <= '0;
      resume_q    <= '0;
      eof_q       <= '0;
      first_upd_q <= '0;
      upd_fat1_q  <= '0;
      upd_fat2_q  <= '0;
      ofs_q       <= '0;
    end else begin
      state_q     <= state_d;
      add_q       <= add_d;
      shift_q     <= shift_d;
      file_q      <= file_d;
      fat1_q      <= fat1_d;
      fat2_q      <= fat2_d;
      acc_q       <= acc_d;
      clust_q     <= clust_d;
      page_q      <= page_d;
      err_q       <= err_d;
      done_q      <= done_d;
      blocks_q    <= blocks_d;
      size_q      <= size_d;
      resume_q    <= resume_d;
      eof_q       <= eof_d;
      first_upd_q <= first_upd_d;
      upd_fat1_q  <= upd_fat1_d;
      upd_fat2_q  <= upd_fat2_d;
      ofs_q       <= ofs_d;
    end
  end

  assign BUSY                = (state_q != S_IDLE);
  assign DONE                = done_q;
  assign ERR                 = err_q;
  assign BLOCKS_TOTAL        = blocks_q;
  assign FILE_SIZE_BYTES     = size_q;
  assign ADDR_RESUME         = resume_q;
  assign CLUST_NUM_EOF       = eof_q;
  assign FIRST_CLUST_UPD_FAT = first_upd_q;
  assign ADDR_UPD_FAT1       = upd_fat1_q;
  assign ADDR_UPD_FAT2       = upd_fat2_q;
  assign FAT_ENTRY_BYTE_OFS  = ofs_q;

endmodule
